// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer with PC, one-entry output buffer, redirect/halt/fault handling
module fetch_controller #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        busy,
   output logic        halted,
   output logic        fault,
   output logic [31:0] fetch_count
);

   // First byte address past the end of instruction memory.
   localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [31:0] pc;
   logic [31:0] pc_n;
   logic        out_valid_n;
   logic        capture;
   logic        accept;
   logic        buf_free;
   logic        redirect_bad;

   assign accept       = out_valid & out_ready;
   assign buf_free     = ~out_valid | accept;
   assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PC_LIMIT);

   assign imem_addr = pc;
   assign busy      = (state == ST_RUN);
   assign halted    = (state == ST_HALT);
   assign fault     = (state == ST_FAULT);

   // State and PC registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_n;
         pc    <= pc_n;
      end
   end

   // Next state, next PC, capture decision and buffer-valid update.
   always_comb begin
      state_n     = state;
      pc_n        = pc;
      capture     = 1'b0;
      out_valid_n = accept ? 1'b0 : out_valid;
      case (state)
         ST_IDLE, ST_HALT: begin
            if (start) state_n = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_valid) begin
               // Redirect flushes the buffer and wins over everything else.
               out_valid_n = 1'b0;
               pc_n        = redirect_pc;
               if (redirect_bad)  state_n = ST_FAULT;
               else if (halt_req) state_n = ST_HALT;
            end else if (halt_req) begin
               state_n = ST_HALT;
            end else if (buf_free) begin
               if (pc >= PC_LIMIT) begin
                  state_n = ST_FAULT;
               end else begin
                  capture     = 1'b1;
                  out_valid_n = 1'b1;
                  pc_n        = pc + 32'd4;
               end
            end
         end
         default: ;
      endcase
   end

   // Output buffer and handshake counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_instr   <= 32'd0;
         out_pc      <= 32'd0;
         fetch_count <= 32'd0;
      end else begin
         out_valid <= out_valid_n;
         if (capture) begin
            out_instr <= imem_instr;
            out_pc    <= pc;
         end
         if (accept) fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller against a transaction-level model
module tb_fetch_controller;

   localparam int          WORDS = 256;
   localparam logic [31:0] LIMIT = 32'd1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        busy;
   logic        halted;
   logic        fault;
   logic [31:0] fetch_count;

   fetch_controller #(.RESET_PC(32'h0), .MEM_WORDS(WORDS)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_addr(imem_addr), .imem_instr(imem_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .busy(busy), .halted(halted), .fault(fault),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // Instruction memory: combinational read, out-of-range reads return a marker.
   logic [31:0] mem [WORDS];
   assign imem_instr = (imem_addr < LIMIT) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

   int n_vec = 0;
   int n_err = 0;

   // Model: mode 0 idle, 1 fetching, 2 halted, 3 faulted; buffer is a queue of {pc, instr}.
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_count;
   logic [63:0] m_buf [$];
   bit          chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_pc    = 32'h0;
      m_count = 32'h0;
      m_buf.delete();
   endtask

   // Per-cycle comparison of every meaningful output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, m_buf.size() != 0});
         chk("imem_addr", imem_addr, m_pc);
         chk("busy", {31'd0, busy}, {31'd0, m_mode == 1});
         chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
         chk("fault", {31'd0, fault}, {31'd0, m_mode == 3});
         chk("fetch_count", fetch_count, m_count);
         if (m_buf.size() != 0) begin
            chk("out_pc", out_pc, m_buf[0][63:32]);
            chk("out_instr", out_instr, m_buf[0][31:0]);
         end
      end
   end

   // Apply one cycle of inputs; model advances with the same inputs at the edge.
   task automatic cyc(input bit st, input bit rdy, input bit rv, input logic [31:0] rpc, input bit hlt);
      int          n_mode;
      logic [31:0] n_pc;
      bit          took;
      @(negedge clk);
      start = st; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc; halt_req = hlt;
      n_mode = m_mode;
      n_pc   = m_pc;
      took   = (m_buf.size() != 0) && rdy;
      @(posedge clk);
      if (took) begin
         void'(m_buf.pop_front());
         m_count = m_count + 1;
      end
      if (m_mode == 0 || m_mode == 2) begin
         if (st) n_mode = 1;
      end else if (m_mode == 1) begin
         if (rv) begin
            m_buf.delete();
            n_pc = rpc;
            if ((rpc % 4) != 0 || rpc >= LIMIT) n_mode = 3;
            else if (hlt)                      n_mode = 2;
         end else if (hlt) begin
            n_mode = 2;
         end else if (m_buf.size() == 0) begin
            if (m_pc >= LIMIT) n_mode = 3;
            else begin
               m_buf.push_back({m_pc, mem[m_pc / 4]});
               n_pc = m_pc + 4;
            end
         end
      end
      m_mode = n_mode;
      m_pc   = n_pc;
      #1;
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      start = 0; out_ready = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_en = 1'b1;
   endtask

   bit saw_last;

   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = (i * 32'h0101_0101) ^ 32'hA500_0013;
      mem[0] = 32'h0020_81B3;
      mem[1] = 32'h0021_C233;
      mem[2] = 32'h4032_02B3;

      // Reset values.
      do_reset();
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst out_pc", out_pc, 32'd0);
      chk("rst out_instr", out_instr, 32'd0);
      chk("rst imem_addr", imem_addr, 32'd0);
      chk("rst flags", {29'd0, busy, halted, fault}, 32'd0);

      // Straight-line fetch with decode always ready.
      cyc(1, 1, 0, 0, 0);
      chk("t1 busy", {31'd0, busy}, 32'd1);
      chk("t1 no entry yet", {31'd0, out_valid}, 32'd0);
      cyc(0, 1, 0, 0, 0);
      chk("t1 pc0", out_pc, 32'h0);
      chk("t1 add", out_instr, 32'h0020_81B3);
      cyc(0, 1, 0, 0, 0);
      chk("t1 pc4", out_pc, 32'h4);
      chk("t1 xor", out_instr, 32'h0021_C233);
      cyc(0, 1, 0, 0, 0);
      chk("t1 pc8", out_pc, 32'h8);
      chk("t1 sub", out_instr, 32'h4032_02B3);
      cyc(0, 1, 0, 0, 0);
      chk("t1 count3", fetch_count, 32'd3);

      // Backpressure.
      do_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0);
         chk("bp hold pc", out_pc, 32'h0);
         chk("bp hold addr", imem_addr, 32'h4);
      end
      cyc(0, 1, 0, 0, 0);
      chk("bp release pc", out_pc, 32'h4);
      chk("bp release count", fetch_count, 32'd1);

      // Redirect flushes the valid entry while it is also accepted.
      do_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("rd entry pc4", out_pc, 32'h4);
      cyc(0, 1, 1, 32'h20, 0);
      chk("rd flush", {31'd0, out_valid}, 32'd0);
      chk("rd count", fetch_count, 32'd2);
      cyc(0, 0, 0, 0, 0);
      chk("rd target", out_pc, 32'h20);

      // Misaligned redirect faults; start ignored.
      do_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h22, 0);
      chk("mis fault", {31'd0, fault}, 32'd1);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      chk("mis sticky", {31'd0, fault}, 32'd1);
      chk("mis no entry", {31'd0, out_valid}, 32'd0);

      // Out-of-range redirect faults.
      do_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 1, 32'h400, 0);
      chk("oor fault", {31'd0, fault}, 32'd1);
      chk("oor pc loaded", imem_addr, 32'h400);

      // Run off the end of memory.
      do_reset();
      saw_last = 1'b0;
      cyc(1, 1, 0, 0, 0);
      for (int i = 0; i < 262; i++) begin
         cyc(0, 1, 0, 0, 0);
         if (out_valid && out_pc == 32'h3FC) saw_last = 1'b1;
      end
      chk("end saw 0x3fc", {31'd0, saw_last}, 32'd1);
      chk("end fault", {31'd0, fault}, 32'd1);
      chk("end count", fetch_count, 32'd256);

      // Halt with an unaccepted entry, resume, then async reset mid-run.
      do_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("halt flag", {31'd0, halted}, 32'd1);
      chk("halt held", {31'd0, out_valid}, 32'd1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("halt drained", fetch_count, 32'd1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("resume pc4", out_pc, 32'h4);
      cyc(0, 1, 0, 0, 0);
      chk_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst addr", imem_addr, 32'h0);
      chk("arst valid", {31'd0, out_valid}, 32'd0);
      chk("arst pc", out_pc, 32'd0);
      chk("arst instr", out_instr, 32'd0);
      chk("arst count", fetch_count, 32'd0);
      chk("arst flags", {29'd0, busy, halted, fault}, 32'd0);
      model_reset();
      do_reset();
      cyc(0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
